// File: rtl/clock_div_bank.sv
// clock_div_bank
//   Bank of independently programmable 50%-duty clock dividers running off
//   mainclock. Each channel counts 0..A and toggles its output when the count
//   hits A, so the divided period is 2*(A+1) mainclock cycles. New settings
//   are written into a per-channel shadow and only take effect at the falling
//   toggle (or right away on an idle channel), so a running output never
//   shows a runt pulse. sync_req restarts every channel whose shadow enable
//   is set, all from the same phase.
//
// Ports
//   mainclock    in   sole clock, all state updates on the rising edge
//   rst_n        in   asynchronous active-low reset
//   cfg_we       in   one-cycle write strobe for the shadow config
//   cfg_chan     in   channel index for the write; out-of-range is ignored
//   cfg_div      in   requested divide field
//   cfg_en       in   requested channel enable
//   sync_req     in   restart all shadow-enabled channels at phase zero
//   out_clocks   out  registered divided clocks
//   out_ticks    out  one-cycle strobe in the first high cycle of each period
//   cfg_pending  out  shadow config written but not yet applied
module clock_div_bank #(
  parameter int CHANNELS    = 8,
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 0
) (
  input  logic                                           mainclock,
  input  logic                                           rst_n,
  input  logic                                           cfg_we,
  input  logic [$clog2(CHANNELS > 1 ? CHANNELS : 2)-1:0] cfg_chan,
  input  logic [DIV_WIDTH-1:0]                           cfg_div,
  input  logic                                           cfg_en,
  input  logic                                           sync_req,
  output logic [CHANNELS-1:0]                            out_clocks,
  output logic [CHANNELS-1:0]                            out_ticks,
  output logic [CHANNELS-1:0]                            cfg_pending
);

  localparam int CW = $clog2(CHANNELS > 1 ? CHANNELS : 2);
  localparam logic [DIV_WIDTH-1:0] DEF_DIV = DIV_WIDTH'(DEFAULT_DIV);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    localparam logic [CW-1:0] IDX = CW'(c);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] act_div_q, act_div_d;
    logic [DIV_WIDTH-1:0] sh_div_q, sh_div_d;
    logic                 act_en_q, act_en_d;
    logic                 sh_en_q, sh_en_d;
    logic                 clk_q, clk_d;
    logic                 tick_q, tick_d;
    logic                 pend_q, pend_d;

    logic                 wr;
    logic                 eff_en;
    logic [DIV_WIDTH-1:0] eff_div;
    logic                 do_sync;

    // Indices at or above CHANNELS never match any IDX, so such writes drop out.
    assign wr      = cfg_we && (cfg_chan == IDX);
    // A write in the same cycle as sync_req lands first and is what sync applies.
    assign eff_div = wr ? cfg_div : sh_div_q;
    assign eff_en  = wr ? cfg_en  : sh_en_q;
    assign do_sync = sync_req && eff_en;

    always_comb begin
      cnt_d     = cnt_q;
      act_div_d = act_div_q;
      act_en_d  = act_en_q;
      sh_div_d  = sh_div_q;
      sh_en_d   = sh_en_q;
      clk_d     = clk_q;
      tick_d    = 1'b0;
      pend_d    = pend_q;

      if (do_sync) begin
        cnt_d     = '0;
        clk_d     = 1'b0;
        act_div_d = eff_div;
        act_en_d  = 1'b1;
        pend_d    = 1'b0;
      end else if (act_en_q) begin
        if (cnt_q == act_div_q) begin
          cnt_d  = '0;
          clk_d  = ~clk_q;
          tick_d = ~clk_q;
          // Falling toggle closes the period: the only safe point to switch.
          // The shadow is copied even with nothing pending since it then
          // already equals the active setting.
          if (clk_q) begin
            act_div_d = sh_div_q;
            act_en_d  = sh_en_q;
            pend_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end else if (pend_q) begin
        // Idle channel has no boundary to wait for.
        act_div_d = sh_div_q;
        act_en_d  = sh_en_q;
        cnt_d     = '0;
        clk_d     = 1'b0;
        pend_d    = 1'b0;
      end

      // A write that coincides with an apply leaves the new value pending.
      if (wr) begin
        sh_div_d = cfg_div;
        sh_en_d  = cfg_en;
        if (!do_sync) pend_d = 1'b1;
      end
    end

    always_ff @(posedge mainclock or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q     <= '0;
        act_div_q <= DEF_DIV;
        act_en_q  <= 1'b0;
        sh_div_q  <= DEF_DIV;
        sh_en_q   <= 1'b0;
        clk_q     <= 1'b0;
        tick_q    <= 1'b0;
        pend_q    <= 1'b0;
      end else begin
        cnt_q     <= cnt_d;
        act_div_q <= act_div_d;
        act_en_q  <= act_en_d;
        sh_div_q  <= sh_div_d;
        sh_en_q   <= sh_en_d;
        clk_q     <= clk_d;
        tick_q    <= tick_d;
        pend_q    <= pend_d;
      end
    end

    assign out_clocks[c]  = clk_q;
    assign out_ticks[c]   = tick_q;
    assign cfg_pending[c] = pend_q;
  end

endmodule

// File: tb/tb_clock_div_bank.sv
module tb_clock_div_bank;
  localparam int CH = 6;
  localparam int DW = 8;
  localparam int CW = 3;

  logic          mainclock;
  logic          rst_n;
  logic          cfg_we;
  logic [CW-1:0] cfg_chan;
  logic [DW-1:0] cfg_div;
  logic          cfg_en;
  logic          sync_req;
  logic [CH-1:0] out_clocks;
  logic [CH-1:0] out_ticks;
  logic [CH-1:0] cfg_pending;

  int checks   = 0;
  int failures = 0;

  clock_div_bank #(.CHANNELS(CH), .DIV_WIDTH(DW), .DEFAULT_DIV(0)) dut (
    .mainclock  (mainclock),
    .rst_n      (rst_n),
    .cfg_we     (cfg_we),
    .cfg_chan   (cfg_chan),
    .cfg_div    (cfg_div),
    .cfg_en     (cfg_en),
    .sync_req   (sync_req),
    .out_clocks (out_clocks),
    .out_ticks  (out_ticks),
    .cfg_pending(cfg_pending)
  );

  initial mainclock = 1'b0;
  always #5 mainclock = ~mainclock;

  // Reference model: each running channel sits at a position within its
  // period of 2*half cycles; low for the first half, high for the second.
  bit m_on[CH];
  int m_pos[CH];
  int m_half[CH];
  int m_sd[CH];
  bit m_se[CH];
  bit m_pend[CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_on[c] = 0; m_pos[c] = 0; m_half[c] = 1;
      m_sd[c] = 0; m_se[c] = 0; m_pend[c] = 0;
    end
  endfunction

  function automatic void model_step();
    if (!rst_n) return;
    for (int c = 0; c < CH; c++) begin
      bit wr;
      int nsd;
      bit nse;
      wr  = cfg_we && (int'(cfg_chan) == c);
      nsd = wr ? int'(cfg_div) : m_sd[c];
      nse = wr ? cfg_en : m_se[c];
      if (sync_req && nse) begin
        m_on[c] = 1; m_half[c] = nsd + 1; m_pos[c] = 0; m_pend[c] = 0;
      end else begin
        if (m_on[c]) begin
          if (m_pos[c] == 2 * m_half[c] - 1) begin
            m_half[c] = m_sd[c] + 1; m_on[c] = m_se[c]; m_pos[c] = 0; m_pend[c] = 0;
          end else begin
            m_pos[c]++;
          end
        end else if (m_pend[c]) begin
          m_half[c] = m_sd[c] + 1; m_on[c] = m_se[c]; m_pos[c] = 0; m_pend[c] = 0;
        end
        if (wr) m_pend[c] = 1;
      end
      m_sd[c] = nsd;
      m_se[c] = nse;
    end
  endfunction

  function automatic logic [CH-1:0] exp_clk();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m_on[c] && (m_pos[c] >= m_half[c]);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_tick();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m_on[c] && (m_pos[c] == m_half[c]);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_pend();
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = m_pend[c];
    return r;
  endfunction

  task automatic set_in(input bit we, input int chan, input int div, input bit en, input bit sync);
    cfg_we = we; cfg_chan = CW'(chan); cfg_div = DW'(div); cfg_en = en; sync_req = sync;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0);
  endtask

  // Advance one clock; returns 1 ns after the edge with the model updated.
  task automatic cycle();
    @(posedge mainclock);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    model_reset();
    #12;
    checks++;
    if ({out_clocks, out_ticks, cfg_pending} !== '0) begin
      failures++;
      $display("FAIL reset_state got clk=%b tick=%b pend=%b exp all 0", out_clocks, out_ticks, cfg_pending);
    end
    @(posedge mainclock); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if ({out_clocks, out_ticks, cfg_pending} !== '0) begin
        failures++;
        $display("FAIL reset_idle got clk=%b tick=%b pend=%b exp all 0", out_clocks, out_ticks, cfg_pending);
      end
    end
  endtask

  task automatic test_div0();
    int toggles = 0, ticks = 0;
    logic prev;
    set_in(1, 0, 0, 1, 0);
    cycle();
    checks++;
    if (cfg_pending[0] !== 1'b1) begin
      failures++; $display("FAIL div0_pending_set got=%b exp=1", cfg_pending[0]);
    end
    idle();
    cycle();
    checks++;
    if (cfg_pending[0] !== 1'b0 || out_clocks[0] !== 1'b0) begin
      failures++; $display("FAIL div0_applied got pend=%b clk=%b exp 0 0", cfg_pending[0], out_clocks[0]);
    end
    prev = out_clocks[0];
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (out_clocks[0] !== prev) toggles++;
      if (out_ticks[0] === 1'b1) ticks++;
      prev = out_clocks[0];
      checks++;
      if ({out_clocks, out_ticks, cfg_pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
        failures++;
        $display("FAIL div0_model got %b/%b/%b exp %b/%b/%b", out_clocks, out_ticks, cfg_pending, exp_clk(), exp_tick(), exp_pend());
      end
    end
    checks++;
    if (toggles != 10 || ticks != 5) begin
      failures++; $display("FAIL div0_rate got toggles=%0d ticks=%0d exp 10 5", toggles, ticks);
    end
  endtask

  task automatic test_div3();
    int rises = 0, ticks = 0, highs = 0;
    logic prev = 1'b0;
    set_in(1, 1, 3, 1, 0);
    cycle();
    idle();
    cycle();
    checks++;
    if (cfg_pending[1] !== 1'b0) begin
      failures++; $display("FAIL div3_pending_clear got=%b exp=0", cfg_pending[1]);
    end
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (out_clocks[1] === 1'b1 && prev === 1'b0) rises++;
      if (out_clocks[1] === 1'b1) highs++;
      if (out_ticks[1] === 1'b1) ticks++;
      prev = out_clocks[1];
      checks++;
      if ({out_clocks, out_ticks, cfg_pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
        failures++;
        $display("FAIL div3_model got %b/%b/%b exp %b/%b/%b", out_clocks, out_ticks, cfg_pending, exp_clk(), exp_tick(), exp_pend());
      end
    end
    checks++;
    if (rises != 5 || ticks != 5 || highs != 20) begin
      failures++; $display("FAIL div3_period got rises=%0d ticks=%0d highs=%0d exp 5 5 20", rises, ticks, highs);
    end
  endtask

  task automatic test_reprogram();
    logic [10:0] seq;
    logic [10:0] want;
    int guard = 0;
    want = 11'b11001100111;
    while (!(m_on[1] && m_pos[1] == m_half[1]) && guard < 20) begin
      cycle(); guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++; $display("FAIL reprog_wait got timeout exp c1 rise");
    end
    set_in(1, 1, 1, 1, 0);
    for (int i = 0; i < 11; i++) begin
      cycle();
      idle();
      seq[i] = out_clocks[1];
      if (i < 3) begin
        checks++;
        if (cfg_pending[1] !== 1'b1) begin
          failures++; $display("FAIL reprog_pending_hold i=%0d got=%b exp=1", i, cfg_pending[1]);
        end
      end
      checks++;
      if ({out_clocks, out_ticks, cfg_pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
        failures++;
        $display("FAIL reprog_model got %b/%b/%b exp %b/%b/%b", out_clocks, out_ticks, cfg_pending, exp_clk(), exp_tick(), exp_pend());
      end
    end
    checks++;
    if (seq !== want) begin
      failures++; $display("FAIL reprog_shape got=%b exp=%b", seq, want);
    end
  endtask

  task automatic test_sync();
    logic [1:0] p[49];
    int r2 = 0, r3 = 0;
    set_in(1, 2, 2, 1, 0); cycle();
    idle();                cycle(); cycle();
    set_in(1, 3, 5, 1, 0); cycle();
    idle();
    for (int i = 0; i < 7; i++) cycle();
    set_in(0, 0, 0, 0, 1);
    cycle();
    idle();
    checks++;
    if (out_clocks[3:2] !== 2'b00 || out_ticks[3:2] !== 2'b00) begin
      failures++; $display("FAIL sync_low got clk=%b tick=%b exp 00 00", out_clocks[3:2], out_ticks[3:2]);
    end
    p[0] = 2'b00;
    for (int k = 1; k <= 48; k++) begin
      cycle();
      p[k] = out_clocks[3:2];
      if (k <= 36 && p[k][0] && !p[k-1][0]) r2++;
      if (k <= 36 && p[k][1] && !p[k-1][1]) r3++;
      checks++;
      if ({out_clocks, out_ticks, cfg_pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
        failures++;
        $display("FAIL sync_model k=%0d got %b/%b/%b exp %b/%b/%b", k, out_clocks, out_ticks, cfg_pending, exp_clk(), exp_tick(), exp_pend());
      end
    end
    checks++;
    if (r2 != 6 || r3 != 3) begin
      failures++; $display("FAIL sync_rises got c2=%0d c3=%0d exp 6 3", r2, r3);
    end
    for (int k = 1; k <= 12; k++) begin
      checks++;
      if (p[k] !== p[k+36]) begin
        failures++; $display("FAIL sync_repeat k=%0d got=%b exp=%b", k, p[k+36], p[k]);
      end
    end
  endtask

  task automatic test_out_of_range_and_disable();
    for (int ch = CH; ch < 8; ch++) begin
      set_in(1, ch, 5, 1, 0);
      cycle();
      checks++;
      if (cfg_pending !== '0 || out_clocks !== exp_clk()) begin
        failures++; $display("FAIL oor_ignored chan=%0d got pend=%b clk=%b exp pend=0 clk=%b", ch, cfg_pending, out_clocks, exp_clk());
      end
    end
    set_in(1, 0, 0, 0, 0);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) cycle();
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (out_clocks[0] !== 1'b0 || out_ticks[0] !== 1'b0 || cfg_pending[0] !== 1'b0) begin
        failures++; $display("FAIL disable_held got clk=%b tick=%b pend=%b exp 0 0 0", out_clocks[0], out_ticks[0], cfg_pending[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int guard = 0;
    // last write wins on an idle channel; the second write overlaps the apply
    set_in(1, 5, 4, 1, 0); cycle();
    set_in(1, 5, 2, 1, 0); cycle();
    idle();
    checks++;
    if (cfg_pending[5] !== 1'b1) begin
      failures++; $display("FAIL b2b_second_pending got=%b exp=1", cfg_pending[5]);
    end
    // write landing exactly on c1's apply point
    while (!(m_on[1] && m_pos[1] == 2 * m_half[1] - 1) && guard < 20) begin
      cycle(); guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++; $display("FAIL b2b_wait got timeout exp c1 apply point");
    end
    set_in(1, 1, 2, 1, 0);
    cycle();
    idle();
    checks++;
    if (cfg_pending[1] !== 1'b1) begin
      failures++; $display("FAIL b2b_apply_collide got=%b exp=1", cfg_pending[1]);
    end
    // write and sync in the same cycle
    set_in(1, 4, 1, 1, 1);
    cycle();
    idle();
    checks++;
    if (cfg_pending[4] !== 1'b0 || out_clocks[4] !== 1'b0) begin
      failures++; $display("FAIL b2b_sync_write got pend=%b clk=%b exp 0 0", cfg_pending[4], out_clocks[4]);
    end
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if ({out_clocks, out_ticks, cfg_pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
        failures++;
        $display("FAIL b2b_model got %b/%b/%b exp %b/%b/%b", out_clocks, out_ticks, cfg_pending, exp_clk(), exp_tick(), exp_pend());
      end
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(5) == 0)
        set_in(1, $urandom_range(7), $urandom_range(5), $urandom_range(3) != 0, $urandom_range(49) == 0);
      else
        set_in(0, 0, 0, 0, $urandom_range(49) == 0);
      cycle();
      checks++;
      if ({out_clocks, out_ticks, cfg_pending} !== {exp_clk(), exp_tick(), exp_pend()}) begin
        failures++;
        if (bad < 10)
          $display("FAIL random_model i=%0d got %b/%b/%b exp %b/%b/%b", i, out_clocks, out_ticks, cfg_pending, exp_clk(), exp_tick(), exp_pend());
        bad++;
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < CH; c++) begin
      set_in(1, c, 3, 1, 0); cycle();
    end
    set_in(0, 0, 0, 0, 1); cycle();
    idle();
    for (int i = 0; i < 5; i++) cycle();
    set_in(1, 2, 7, 1, 0); cycle();
    idle();
    checks++;
    if (out_clocks !== {CH{1'b1}} || cfg_pending[2] !== 1'b1) begin
      failures++; $display("FAIL rstmid_pre got clk=%b pend=%b exp all-high pend2=1", out_clocks, cfg_pending);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({out_clocks, out_ticks, cfg_pending} !== '0) begin
      failures++; $display("FAIL rstmid_async got clk=%b tick=%b pend=%b exp all 0", out_clocks, out_ticks, cfg_pending);
    end
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++;
      if ({out_clocks, out_ticks, cfg_pending} !== '0) begin
        failures++; $display("FAIL rstmid_after got clk=%b tick=%b pend=%b exp all 0", out_clocks, out_ticks, cfg_pending);
      end
    end
  endtask

  initial begin
    test_reset();
    test_div0();
    test_div3();
    test_reprogram();
    test_sync();
    test_out_of_range_and_disable();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
